// File: rtl/seg_pkg.sv
// Seven-segment pattern constants shared by the scan controller.
// Segments are active-low, ordered {g,f,e,d,c,b,a}; the dp bit sits at SEG_DP.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int SEG_DP = 7;

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational; full 0-F coverage.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_OFF;
    unique case (nibble)
      4'h0: segs = SEG_0;
      4'h1: segs = SEG_1;
      4'h2: segs = SEG_2;
      4'h3: segs = SEG_3;
      4'h4: segs = SEG_4;
      4'h5: segs = SEG_5;
      4'h6: segs = SEG_6;
      4'h7: segs = SEG_7;
      4'h8: segs = SEG_8;
      4'h9: segs = SEG_9;
      4'hA: segs = SEG_A;
      4'hB: segs = SEG_B;
      4'hC: segs = SEG_C;
      4'hD: segs = SEG_D;
      4'hE: segs = SEG_E;
      4'hF: segs = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-coherent capture,
// leading-zero blanking, global blank and anti-ghosting dead time.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int DEAD_CYCLES    = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] num,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_blank,
  input  logic                    blank,
  output logic [NUM_DIGITS-1:0]   An_display,
  output logic [7:0]              BCD_display,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    started;
  logic [4*NUM_DIGITS-1:0] shadow_num;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    wrap;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              nib;
  logic                    dp_bit;
  logic                    lz_bit;
  logic                    sel_valid;
  logic [NUM_DIGITS-1:0]   sel_an;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [7:0]              bcd_d;

  assign wrap = (cnt == CW'(REFRESH_CYCLES - 1));

  // The first cycle out of reset holds the counter so frame 0 starts cleanly.
  assign capture = !started || (wrap && idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      started     <= 1'b0;
      shadow_num  <= '0;
      shadow_dp   <= '0;
      An_display  <= '1;
      BCD_display <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      started <= 1'b1;
      if (started) begin
        if (wrap) begin
          cnt <= '0;
          idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (capture) begin
        shadow_num <= num;
        shadow_dp  <= dp;
      end
      frame_start <= capture;
      An_display  <= an_d;
      BCD_display <= bcd_d;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (shadow_num[i*4 +: 4] == 4'h0);
      lz_mask[i] = lz_blank & zero_run & (i != 0);
    end
  end

  always_comb begin
    nib       = '0;
    dp_bit    = 1'b0;
    lz_bit    = 1'b0;
    sel_valid = 1'b0;
    sel_an    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx) == i) begin
        nib       = shadow_num[i*4 +: 4];
        dp_bit    = shadow_dp[i];
        lz_bit    = lz_mask[i];
        sel_valid = 1'b1;
        sel_an[i] = 1'b0;
      end
    end
  end

  seg_hex_decoder u_dec (
    .nibble (nib),
    .segs   (seg_raw)
  );

  always_comb begin
    an_d  = '1;
    bcd_d = 8'hFF;
    if (cnt >= CW'(DEAD_CYCLES) && sel_valid) begin
      an_d          = sel_an;
      bcd_d[SEG_DP] = ~dp_bit;
      bcd_d[6:0]    = lz_bit ? SEG_OFF : seg_raw;
    end
    if (blank) an_d = '1;
  end

endmodule
